// File: rtl/usb_rst_pkg.sv
// Shared types and constants for the USB reset sequencer.
package usb_rst_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // Register word addresses
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_HOLD   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_SETTLE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd3;

    // CTRL write bit positions
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;
    localparam int unsigned CTRL_FORCE    = 2;
    localparam int unsigned CTRL_DONE_CLR = 3;

    // STATUS read bit positions
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_IRQ_EN = 1;
    localparam int unsigned STAT_FORCE  = 2;
    localparam int unsigned STAT_DONE   = 3;
    localparam int unsigned STAT_IN_RST = 4;

endpackage

// File: rtl/usb_rst_timer.sv
// Loadable down-counter; a zero load value is clamped to one so every phase
// lasts at least a cycle. expire_c_o flags the last cycle of a phase.
module usb_rst_timer
    import usb_rst_pkg::*;
#(
    parameter int unsigned      CNT_W     = 24,
    parameter logic [CNT_W-1:0] RESET_VAL = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             clear_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_c_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load beats clear beats decrement
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
        end else if (clear_i) begin
            count_d = '0;
        end else if (dec_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign expire_c_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/usb_rst_sequencer.sv
// Avalon-MM slave that drives a timed reset pulse to the USB controller:
// hold the chip in reset, wait for it to settle, then flag completion.
module usb_rst_sequencer
    import usb_rst_pkg::*;
#(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned HOLD_DEFAULT   = 500000,
    parameter int unsigned SETTLE_DEFAULT = 100000,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              usb_rst_n,
    output logic              irq
);

    localparam logic [CNT_W-1:0] HOLD_RST   = CNT_W'(HOLD_DEFAULT);
    localparam logic [CNT_W-1:0] SETTLE_RST = CNT_W'(SETTLE_DEFAULT);
    localparam logic [CNT_W-1:0] COUNT_RST  =
        (HOLD_DEFAULT == 0) ? CNT_W'(1) : CNT_W'(HOLD_DEFAULT);
    localparam state_e STATE_RST = AUTO_START ? ST_HOLD : ST_IDLE;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             irq_en_q, irq_en_d;
    logic             force_q, force_d;
    logic             done_q, done_d;
    logic             usb_rst_n_q, usb_rst_n_d;
    logic             irq_q, irq_d;

    logic             wr_c, ctrl_wr_c, start_req_c, done_clr_c;
    logic             tmr_load, tmr_clear, tmr_dec, tmr_expire;
    logic [CNT_W-1:0] tmr_val, tmr_count;
    logic             start_acc, done_set;
    logic             unused_wdata;

    // Bus decode
    assign wr_c        = chipselect & ~write_n;
    assign ctrl_wr_c   = wr_c & (address == ADDR_CTRL);
    assign start_req_c = ctrl_wr_c & writedata[CTRL_START];
    assign done_clr_c  = ctrl_wr_c & writedata[CTRL_DONE_CLR];
    assign unused_wdata = ^writedata;

    usb_rst_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (COUNT_RST)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .clear_i    (tmr_clear),
        .dec_i      (tmr_dec),
        .count_o    (tmr_count),
        .expire_c_o (tmr_expire)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and timer control; phase lengths are sampled at
    // each load point so register writes during a phase apply to the next one
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_clear = 1'b0;
        tmr_dec   = 1'b0;
        start_acc = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req_c) begin
                    start_acc = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = hold_q;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = settle_q;
                    state_d  = ST_SETTLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    tmr_clear = 1'b1;
                    done_set  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register file next values and registered outputs
    always_comb begin
        hold_d   = hold_q;
        settle_d = settle_q;
        irq_en_d = irq_en_q;
        force_d  = force_q;
        done_d   = done_q;
        if (wr_c) begin
            case (address)
                ADDR_CTRL: begin
                    irq_en_d = writedata[CTRL_IRQ_EN];
                    force_d  = writedata[CTRL_FORCE];
                end
                ADDR_HOLD:   hold_d   = writedata[CNT_W-1:0];
                ADDR_SETTLE: settle_d = writedata[CNT_W-1:0];
                default: begin
                end
            endcase
        end
        // Completion beats any clear; a new start always clears
        if (done_set) begin
            done_d = 1'b1;
        end else if (start_acc || done_clr_c) begin
            done_d = 1'b0;
        end
        usb_rst_n_d = ~((state_d == ST_HOLD) | force_d);
        irq_d       = done_d & irq_en_d;
    end

    // Register file flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= HOLD_RST;
            settle_q    <= SETTLE_RST;
            irq_en_q    <= 1'b0;
            force_q     <= 1'b0;
            done_q      <= 1'b0;
            usb_rst_n_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            settle_q    <= settle_d;
            irq_en_q    <= irq_en_d;
            force_q     <= force_d;
            done_q      <= done_d;
            usb_rst_n_q <= usb_rst_n_d;
            irq_q       <= irq_d;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[STAT_BUSY]   = (state_q != ST_IDLE);
                readdata[STAT_IRQ_EN] = irq_en_q;
                readdata[STAT_FORCE]  = force_q;
                readdata[STAT_DONE]   = done_q;
                readdata[STAT_IN_RST] = ~usb_rst_n_q;
            end
            ADDR_HOLD:   readdata = DATA_W'(hold_q);
            ADDR_SETTLE: readdata = DATA_W'(settle_q);
            ADDR_COUNT:  readdata = DATA_W'(tmr_count);
            default:     readdata = '0;
        endcase
    end

    assign usb_rst_n = usb_rst_n_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Randomised and directed bench for usb_rst_sequencer with a timeline-based
// reference model and a queue-fed output monitor.
module tb_usb_rst_sequencer;

    localparam int unsigned CNT_W      = 24;
    localparam int          HOLD_DEF   = 4;
    localparam int          SETTLE_DEF = 3;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic        usb_rst_n;
    logic        irq;

    usb_rst_sequencer #(
        .CNT_W          (CNT_W),
        .HOLD_DEFAULT   (HOLD_DEF),
        .SETTLE_DEFAULT (SETTLE_DEF),
        .AUTO_START     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .usb_rst_n  (usb_rst_n),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        irq;
        logic        chk_rd;
        logic [1:0]  addr;
        logic [31:0] rd;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    bit   rst_hold = 1'b1;

    // Reference model: a sequence is described by absolute edge times
    int now, t_hold_end, t_done, count_idle, m_hold, m_settle;
    bit busy, settle_known, m_irq_en, m_force, m_done;

    function automatic int clamp1(int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit in_hold();
        return busy && (now < t_hold_end);
    endfunction

    function automatic int model_count();
        if (in_hold()) return t_hold_end - now;
        if (busy) return t_done - now;
        return count_idle;
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: begin
                v[0] = busy;
                v[1] = m_irq_en;
                v[2] = m_force;
                v[3] = m_done;
                v[4] = in_hold() || m_force;
            end
            2'd1: v = 32'(m_hold);
            2'd2: v = 32'(m_settle);
            default: v = 32'(model_count());
        endcase
        return v;
    endfunction

    // State right after reset: an automatic sequence that started at edge 0
    function automatic void model_reset();
        now          = 0;
        m_hold       = HOLD_DEF;
        m_settle     = SETTLE_DEF;
        m_irq_en     = 1'b0;
        m_force      = 1'b0;
        m_done       = 1'b0;
        busy         = 1'b1;
        settle_known = 1'b0;
        t_hold_end   = clamp1(HOLD_DEF);
        t_done       = 0;
        count_idle   = clamp1(HOLD_DEF);
    endfunction

    function automatic void model_edge(bit wr, logic [1:0] a, logic [31:0] d);
        bit was_busy;
        bit fin;
        bit start;
        int old_hold;
        int old_settle;
        old_hold   = m_hold;
        old_settle = m_settle;
        now++;
        was_busy = busy;
        fin      = 1'b0;
        if (busy && !settle_known && now == t_hold_end) begin
            t_done       = now + clamp1(old_settle);
            settle_known = 1'b1;
        end else if (busy && settle_known && now == t_done) begin
            busy       = 1'b0;
            fin        = 1'b1;
            count_idle = 0;
        end
        start = wr && (a == 2'd0) && d[0] && !was_busy;
        if (start) begin
            busy         = 1'b1;
            t_hold_end   = now + clamp1(old_hold);
            settle_known = 1'b0;
        end
        if (fin) m_done = 1'b1;
        else if (start) m_done = 1'b0;
        else if (wr && (a == 2'd0) && d[3]) m_done = 1'b0;
        if (wr) begin
            case (a)
                2'd0: begin
                    m_irq_en = d[1];
                    m_force  = d[2];
                end
                2'd1: m_hold   = int'(d[CNT_W-1:0]);
                2'd2: m_settle = int'(d[CNT_W-1:0]);
                default: begin
                end
            endcase
        end
    endfunction

    function automatic void push_exp(logic [1:0] a, bit chk);
        exp_t e;
        e.rst_n  = !(in_hold() || m_force);
        e.irq    = m_done && m_irq_en;
        e.chk_rd = chk;
        e.addr   = a;
        e.rd     = model_read(a);
        expq.push_back(e);
    endfunction

    // One bus cycle: drive at the falling edge, predict the post-edge outputs
    task automatic cyc(bit cs, bit wn, logic [1:0] a, logic [31:0] d);
        @(negedge clk);
        reset_n    = !rst_hold;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        if (reset_n) model_edge(cs && !wn, a, d);
        else model_reset();
        push_exp(a, cs && wn);
    endtask

    task automatic wr_reg(logic [1:0] a, logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(logic [1:0] a, int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, a, 32'd0);
    endtask

    // Poll COUNT until the model reaches the requested phase/count
    task automatic wait_count(bit want_hold, int val);
        int n;
        n = 0;
        while (!(busy && (in_hold() == want_hold) && model_count() == val) && n < 60) begin
            cyc(1'b1, 1'b1, 2'd3, 32'd0);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL wait_count: no count=%0d in phase hold=%0d within 60 cycles", val, want_hold);
        end
    endtask

    // Assert reset asynchronously between clock edges
    task automatic pulse_reset();
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        model_reset();
        push_exp(2'd0, 1'b1);
        push_exp(2'd0, 1'b1);
        rst_hold = 1'b1;
        reset_n  = 1'b0;
    endtask

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, got, want);
        end
    endfunction

    // Monitor: compare outputs after every edge and on asynchronous reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("usb_rst_n", 32'(usb_rst_n), 32'(e.rst_n));
                check("irq", 32'(irq), 32'(e.irq));
                if (e.chk_rd) check($sformatf("readdata[a%0d]", e.addr), readdata, e.rd);
            end
        end
    end

    initial begin
        int r;
        model_reset();

        // Auto-start sequence out of reset, default hold/settle
        rd_reg(2'd0, 3);
        rst_hold = 1'b0;
        rd_reg(2'd0, 10);

        // Programmed pulse with IRQ, then clear
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd2, 32'd2);
        wr_reg(2'd0, 32'h2);
        wr_reg(2'd0, 32'h3);
        rd_reg(2'd0, 9);
        wr_reg(2'd0, 32'hA);
        rd_reg(2'd0, 2);

        // START during HOLD is ignored
        wr_reg(2'd0, 32'h3);
        wait_count(1'b1, 3);
        wr_reg(2'd0, 32'h3);
        rd_reg(2'd3, 10);

        // Zero lengths clamp to one; done set collides with DONE_CLR
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'h1);
        rd_reg(2'd0, 1);
        wr_reg(2'd0, 32'h8);
        rd_reg(2'd0, 3);

        // FORCE holds the chip in reset while idle
        wr_reg(2'd0, 32'h4);
        rd_reg(2'd0, 3);
        wr_reg(2'd0, 32'h0);
        rd_reg(2'd0, 2);

        // START with DONE_CLR, then reset in the middle of SETTLE
        wr_reg(2'd1, 32'd6);
        wr_reg(2'd2, 32'd5);
        wr_reg(2'd0, 32'h9);
        wait_count(1'b0, 2);
        pulse_reset();
        rd_reg(2'd0, 2);
        rst_hold = 1'b0;
        rd_reg(2'd1, 1);
        rd_reg(2'd2, 1);
        rd_reg(2'd0, 10);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) rd_reg(2'($urandom_range(0, 3)), 1);
            else if (r < 60) wr_reg(2'd1, 32'($urandom_range(0, 6)));
            else if (r < 70) wr_reg(2'd2, 32'($urandom_range(0, 6)));
            else if (r < 88) wr_reg(2'd0, {28'd0, 1'($urandom_range(0, 1)),
                                            1'($urandom_range(0, 3) == 0),
                                            1'($urandom_range(0, 1)),
                                            1'($urandom_range(0, 1))});
            else if (r < 92) wr_reg(2'd3, $urandom);
            else cyc(1'b0, 1'b1, 2'd0, 32'd0);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
